// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-path bundle between the value/enable source and the scan controller.
// The controller takes the slave side; whatever feeds it takes the master side.
interface seven_seg_scan_ctrl_if;
    logic       load;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] AplusB;
    logic [3:0] AminusB;
    logic [3:0] digit_en;
    logic [3:0] anode;
    logic [3:0] digit_val;
    logic       pending;
    logic       frame_done;

    modport master (
        output load, A, B, AplusB, AminusB, digit_en,
        input  anode, digit_val, pending, frame_done
    );

    modport slave (
        input  load, A, B, AplusB, AminusB, digit_en,
        output anode, digit_val, pending, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronised value shadowing.
//   state | meaning
//   BLANK | all anodes off between digits; the last clock advances idx (idx 3 -> 0 commits staging)
//   SHOW  | digit idx is driven for REFRESH_DIV clocks, lit only if digit_en[idx]
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int SW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [SW-1:0] SHOW_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t           state, state_n;
    logic [1:0]       idx, idx_n;
    logic [SW-1:0]    show_cnt;
    logic [BW-1:0]    blank_cnt;
    logic [3:0][3:0]  staging, shadow, shadow_n;
    logic             commit, lit, frame_n;
    logic [3:0]       anode_n, val_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        commit  = 1'b0;
        frame_n = 1'b0;
        case (state)
            BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    state_n = SHOW;
                    idx_n   = idx + 2'd1;
                    commit  = (idx == 2'd3);
                end
            end
            SHOW: begin
                if (show_cnt == SHOW_LAST) begin
                    state_n = BLANK;
                    frame_n = (idx == 2'd3);
                end
            end
            default: state_n = BLANK;
        endcase
        // Outputs are computed from the post-edge state so they line up with it.
        shadow_n = commit ? staging : shadow;
        lit      = (state_n == SHOW) && bus.digit_en[idx_n];
        anode_n  = lit ? ~(4'b0001 << idx_n) : 4'b1111;
        val_n    = lit ? shadow_n[idx_n] : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BLANK;
            idx            <= 2'd3;
            show_cnt       <= '0;
            blank_cnt      <= '0;
            staging        <= '0;
            shadow         <= '0;
            bus.anode      <= 4'b1111;
            bus.digit_val  <= 4'h0;
            bus.pending    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            show_cnt  <= (state == SHOW  && state_n == SHOW)  ? show_cnt  + 1'b1 : '0;
            blank_cnt <= (state == BLANK && state_n == BLANK) ? blank_cnt + 1'b1 : '0;
            shadow    <= shadow_n;
            // A load on the commit edge wins the pending flag for the following frame.
            if (bus.load) begin
                staging     <= {bus.AminusB, bus.AplusB, bus.B, bus.A};
                bus.pending <= 1'b1;
            end else if (commit) begin
                bus.pending <= 1'b0;
            end
            bus.anode      <= anode_n;
            bus.digit_val  <= val_n;
            bus.frame_done <= frame_n;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed steps plus random loads/enables against a timeline model.
module tb_seven_seg_scan_ctrl;
    localparam int R  = 4;
    localparam int BK = 2;
    localparam int SL = R + BK;
    localparam int P  = 4 * SL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if bus ();

    seven_seg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(BK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int         n;
    logic [3:0] m_stage  [4];
    logic [3:0] m_shadow [4];
    logic       m_pending;
    int         n_cmp = 0;
    int         n_err = 0;

    // The model works from elapsed clocks since reset: position in the frame decides slot and lit-ness.
    task automatic tick();
        logic [3:0] en;
        logic [3:0] e_an, e_val;
        logic       e_fd, lit;
        int         q, s, w;
        en = bus.digit_en;
        @(posedge clk);
        if (reset) begin
            n = 0;
            for (int i = 0; i < 4; i++) begin
                m_stage[i]  = 4'h0;
                m_shadow[i] = 4'h0;
            end
            m_pending = 1'b0;
        end else begin
            n++;
            if (n % P == BK) begin
                for (int i = 0; i < 4; i++) m_shadow[i] = m_stage[i];
                m_pending = 1'b0;
            end
            if (bus.load) begin
                m_stage[0] = bus.A;
                m_stage[1] = bus.B;
                m_stage[2] = bus.AplusB;
                m_stage[3] = bus.AminusB;
                m_pending  = 1'b1;
            end
        end
        #1;
        bus.load = 1'b0;
        q   = n % P;
        s   = q / SL;
        w   = q % SL;
        lit = (w >= BK) && en[s];
        e_an  = lit ? ~(4'b0001 << s) : 4'b1111;
        e_val = lit ? m_shadow[s] : 4'h0;
        e_fd  = (n > 0) && (q == 0);

        n_cmp++;
        assert (bus.anode === e_an) else begin
            n_err++;
            $error("FAIL anode n=%0d observed=%b expected=%b", n, bus.anode, e_an);
        end
        n_cmp++;
        assert (bus.digit_val === e_val) else begin
            n_err++;
            $error("FAIL digit_val n=%0d observed=%h expected=%h", n, bus.digit_val, e_val);
        end
        n_cmp++;
        assert (bus.pending === m_pending) else begin
            n_err++;
            $error("FAIL pending n=%0d observed=%b expected=%b", n, bus.pending, m_pending);
        end
        n_cmp++;
        assert (bus.frame_done === e_fd) else begin
            n_err++;
            $error("FAIL frame_done n=%0d observed=%b expected=%b", n, bus.frame_done, e_fd);
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Advance until the next edge would land the model at frame position pos (bounded by one frame).
    task automatic run_to(input int pos);
        for (int i = 0; i < P && ((n + 1) % P != pos); i++) tick();
    endtask

    task automatic set_vals(input logic [3:0] a, b, c, d);
        bus.A       = a;
        bus.B       = b;
        bus.AplusB  = c;
        bus.AminusB = d;
        bus.load    = 1'b1;
    endtask

    initial begin
        n         = 0;
        m_pending = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_stage[i]  = 4'h0;
            m_shadow[i] = 4'h0;
        end
        bus.load = 1'b0;
        bus.A = 4'h0; bus.B = 4'h0; bus.AplusB = 4'h0; bus.AminusB = 4'h0;
        bus.digit_en = 4'b1111;
        reset = 1'b1;
        run(3);
        reset = 1'b0;

        // Free-running frames with all digits enabled.
        run(2 * P);

        // Load during digit 1 SHOW, then watch through the next frame.
        run_to(SL + BK + 1);
        set_vals(4'h3, 4'h5, 4'h8, 4'hE);
        tick();
        run(P + SL);

        // Two loads in one frame; last wins.
        run_to(BK + 1);
        set_vals(4'h1, 4'h1, 4'h1, 4'h1);
        tick();
        run(3);
        set_vals(4'h2, 4'h2, 4'h2, 4'h2);
        tick();
        run(P);

        // Load coincident with the commit edge.
        run_to(BK);
        set_vals(4'h9, 4'hA, 4'hB, 4'hC);
        tick();
        run(2 * P);

        // Digits 0 and 2 disabled.
        bus.digit_en = 4'b1010;
        run(P + 3);
        bus.digit_en = 4'b1111;

        // Randomised loads and enable changes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_vals(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 15) == 0)
                bus.digit_en = 4'($urandom);
            tick();
        end
        bus.digit_en = 4'b1111;

        // Reset during digit 2 SHOW with a load pending.
        run_to(2 * SL + BK);
        set_vals(4'h7, 4'h6, 4'h5, 4'h4);
        tick();
        run(1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(P + SL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
